// File: rtl/uart_receiver.sv
// UART receive stage: oversamples the synchronized serial line with the shared baud tick
// and recovers start/data/optional parity/stop, reporting the word with a one-cycle RxDone.
module uart_receiver #(
   parameter int DataBits  = 8,
   parameter int ClkTicks  = 16,
   parameter bit ParityEn  = 1'b1,
   parameter bit ParityOdd = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                tick,
   input  logic                RxIn,
   output logic [DataBits-1:0] DataOut,
   output logic                RxDone,
   output logic                ParityErr,
   output logic                FrameErr,
   output logic                Busy
);

   localparam int CntW = (ClkTicks > 1) ? $clog2(ClkTicks) : 1;
   localparam int BitW = (DataBits > 1) ? $clog2(DataBits) : 1;
   localparam logic [CntW-1:0] HalfLast = CntW'(ClkTicks / 2 - 1);
   localparam logic [CntW-1:0] FullLast = CntW'(ClkTicks - 1);
   localparam logic [BitW-1:0] LastBit  = BitW'(DataBits - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
   } stateT;

   stateT               state;
   logic                rxMeta;
   logic                rxSync;
   logic [CntW-1:0]     tickCnt;
   logic [BitW-1:0]     bitCnt;
   logic [DataBits-1:0] shiftReg;
   logic                parAcc;

   // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= RxIn;
         rxSync <= rxMeta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tickCnt   <= '0;
         bitCnt    <= '0;
         shiftReg  <= '0;
         parAcc    <= 1'b0;
         DataOut   <= '0;
         RxDone    <= 1'b0;
         ParityErr <= 1'b0;
         FrameErr  <= 1'b0;
      end else begin
         RxDone <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxSync) begin
                  tickCnt <= '0;
                  state   <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (tickCnt == HalfLast) begin
                     if (!rxSync) begin
                        tickCnt <= '0;
                        bitCnt  <= '0;
                        parAcc  <= 1'b0;
                        state   <= DATA;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tickCnt == FullLast) begin
                     // LSB arrives first, so new bits enter at the top and shift down
                     shiftReg <= (shiftReg >> 1) | (DataBits'(rxSync) << (DataBits - 1));
                     parAcc   <= parAcc ^ rxSync;
                     tickCnt  <= '0;
                     if (bitCnt == LastBit) begin
                        state <= ParityEn ? PARITY : STOP;
                     end else begin
                        bitCnt <= bitCnt + 1'b1;
                     end
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  if (tickCnt == FullLast) begin
                     parAcc  <= parAcc ^ rxSync;
                     tickCnt <= '0;
                     state   <= STOP;
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (tickCnt == FullLast) begin
                     DataOut   <= shiftReg;
                     ParityErr <= ParityEn & (parAcc ^ ParityOdd);
                     FrameErr  <= ~rxSync;
                     RxDone    <= 1'b1;
                     tickCnt   <= '0;
                     // A low stop bit means a break or stuck line: wait for it to recover
                     state     <= rxSync ? IDLE : WAIT_HIGH;
                  end else begin
                     tickCnt <= tickCnt + 1'b1;
                  end
               end
            end
            WAIT_HIGH: begin
               if (rxSync) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table-driven frames, hand-written corner sequences and
// randomized frames checked against a parity/framing model computed from the frame contents.
module tb_uart_receiver;

   localparam int BitClks = 64;   // 16 ticks per bit, one tick every 4 clocks

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick    = 1'b0;
   logic       RxIn    = 1'b1;
   logic [7:0] DataOut;
   logic       RxDone;
   logic       ParityErr;
   logic       FrameErr;
   logic       Busy;

   uart_receiver #(
      .DataBits (8),
      .ClkTicks (16),
      .ParityEn (1'b1),
      .ParityOdd(1'b0)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .RxIn     (RxIn),
      .DataOut  (DataOut),
      .RxDone   (RxDone),
      .ParityErr(ParityErr),
      .FrameErr (FrameErr),
      .Busy     (Busy)
   );

   always #5 clk = ~clk;

   int tickDiv = 0;
   always @(negedge clk) begin
      tick    = (tickDiv == 3);
      tickDiv = (tickDiv + 1) % 4;
   end

   typedef struct {
      logic [7:0] data;
      bit         pbit;
      bit         stopBit;
      int         gap;
      logic [7:0] expData;
      bit         expPerr;
      bit         expFerr;
   } vecT;

   typedef struct {
      logic [7:0] data;
      bit         perr;
      bit         ferr;
   } obsT;

   obsT        obsQ[$];
   int         total    = 0;
   int         bad      = 0;
   int         wideCnt  = 0;
   int         holdViol = 0;
   logic [7:0] lastData = 8'h00;
   bit         lastPerr = 1'b0;
   bit         lastFerr = 1'b0;
   bit         prevDone = 1'b0;

   // Observer: records every completed frame, flags wide pulses and outputs changing between pulses
   always @(negedge clk) begin
      if (!reset_n) begin
         lastData = 8'h00;
         lastPerr = 1'b0;
         lastFerr = 1'b0;
         prevDone = 1'b0;
      end else begin
         if (RxDone) begin
            if (prevDone) wideCnt++;
            obsQ.push_back('{DataOut, ParityErr, FrameErr});
            lastData = DataOut;
            lastPerr = ParityErr;
            lastFerr = FrameErr;
         end else if (DataOut !== lastData || ParityErr !== lastPerr || FrameErr !== lastFerr) begin
            holdViol++;
         end
         prevDone = RxDone;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input logic b, input int clks);
      RxIn = b;
      repeat (clks) @(negedge clk);
   endtask

   task automatic sendFrame(input logic [7:0] d, input bit pbit, input bit stopBit);
      sendBit(1'b0, BitClks);
      for (int i = 0; i < 8; i++) sendBit(d[i], BitClks);
      sendBit(pbit, BitClks);
      sendBit(stopBit, BitClks);
   endtask

   task automatic checkFrame(input string name, input logic [7:0] expData, input bit expPerr,
                             input bit expFerr);
      obsT o;
      check({name, "_doneCount"}, 32'(obsQ.size()), 32'd1);
      if (obsQ.size() > 0) begin
         o = obsQ.pop_front();
         check({name, "_data"}, 32'(o.data), 32'(expData));
         check({name, "_parityErr"}, 32'(o.perr), 32'(expPerr));
         check({name, "_frameErr"}, 32'(o.ferr), 32'(expFerr));
      end
      obsQ.delete();
   endtask

   task automatic checkResetOutputs(input string name);
      check({name, "_DataOut"}, 32'(DataOut), 32'd0);
      check({name, "_RxDone"}, 32'(RxDone), 32'd0);
      check({name, "_ParityErr"}, 32'(ParityErr), 32'd0);
      check({name, "_FrameErr"}, 32'(FrameErr), 32'd0);
      check({name, "_Busy"}, 32'(Busy), 32'd0);
   endtask

   vecT vecs[7];

   initial begin
      logic [7:0] d;
      bit         pbit;
      bit         stopBit;
      bit         expPerr;
      int         gap;
      int         ones;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 20, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 20, 8'hA5, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b1, 20, 8'h3C, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 1'b0, 1'b1, 0,  8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 1'b0, 1'b1, 20, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{8'h07, 1'b1, 1'b1, 10, 8'h07, 1'b0, 1'b0};
      vecs[6] = '{8'h07, 1'b0, 1'b1, 10, 8'h07, 1'b1, 1'b0};

      // Reset state, both while held and just after release
      repeat (4) @(negedge clk);
      checkResetOutputs("resetHeld");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      checkResetOutputs("resetReleased");

      // Table frames; entry 3 -> 4 is back-to-back with no idle gap
      for (int i = 0; i < 7; i++) begin
         sendFrame(vecs[i].data, vecs[i].pbit, vecs[i].stopBit);
         checkFrame($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expPerr, vecs[i].expFerr);
         check($sformatf("vec%0d_busyAfter", i), 32'(Busy), 32'd0);
         if (vecs[i].gap > 0) sendBit(1'b1, vecs[i].gap);
      end

      // Short low glitch shorter than half a bit must not start a frame
      sendBit(1'b0, 16);
      sendBit(1'b1, 100);
      check("glitch_noDone", 32'(obsQ.size()), 32'd0);
      check("glitch_idle", 32'(Busy), 32'd0);
      sendFrame(8'h01, 1'b1, 1'b1);
      checkFrame("afterGlitch", 8'h01, 1'b0, 1'b0);
      sendBit(1'b1, 20);

      // Stop bit low and line held low for three bit times in total
      sendFrame(8'h55, 1'b0, 1'b0);
      sendBit(1'b0, 2 * BitClks);
      check("break_busyWhileLow", 32'(Busy), 32'd1);
      checkFrame("break", 8'h55, 1'b0, 1'b1);
      sendBit(1'b1, 20);
      check("break_idleAfterRise", 32'(Busy), 32'd0);
      check("break_noSecondDone", 32'(obsQ.size()), 32'd0);

      // Reset asserted in the middle of data bit 3 discards the frame
      d = 8'h42;
      sendBit(1'b0, BitClks);
      for (int i = 0; i < 3; i++) sendBit(d[i], BitClks);
      RxIn = d[3];
      repeat (BitClks / 2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkResetOutputs("midReset");
      RxIn = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      sendBit(1'b1, 100);
      check("midReset_noDone", 32'(obsQ.size()), 32'd0);
      sendFrame(8'h81, 1'b0, 1'b1);
      checkFrame("afterReset", 8'h81, 1'b0, 1'b0);
      sendBit(1'b1, 20);

      // Random frames against the parity/framing model
      for (int k = 0; k < 20; k++) begin
         d       = 8'($urandom_range(0, 255));
         pbit    = 1'($urandom_range(0, 1));
         stopBit = ($urandom_range(0, 4) != 0);
         ones    = $countones(d) + int'(pbit);
         expPerr = (ones % 2) != 0;
         sendFrame(d, pbit, stopBit);
         checkFrame($sformatf("rand%0d", k), d, expPerr, !stopBit);
         gap = stopBit ? int'($urandom_range(0, 40)) : 20 + int'($urandom_range(0, 40));
         if (gap > 0) sendBit(1'b1, gap);
      end

      sendBit(1'b1, 20);
      check("pulseWidth", 32'(wideCnt), 32'd0);
      check("holdBetweenDone", 32'(holdViol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
